// File: rtl/modinv_arbiter.sv
// Round-robin arbiter sharing one modular_inverse engine among NUM_REQ
// requesters; returns each result with a one-hot valid to its owner.
module modinv_arbiter #(
  parameter int WIDTH          = 512,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1 << 20
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [NUM_REQ-1:0]       req_in,
  input  logic [NUM_REQ*WIDTH-1:0] a_in,
  input  logic [NUM_REQ*WIDTH-1:0] base_in,
  output logic [NUM_REQ-1:0]       ack_out,
  output logic [WIDTH-1:0]         result_out,
  output logic [NUM_REQ-1:0]       result_valid_out,
  output logic                     result_error_out,
  output logic                     timeout_out,
  output logic                     busy_out,
  output logic [WIDTH-1:0]         engine_a_out,
  output logic [WIDTH-1:0]         engine_base_out,
  output logic                     engine_valid_out,
  input  logic [WIDTH-1:0]         engine_b_in,
  input  logic                     engine_valid_in,
  input  logic                     engine_error_in,
  input  logic                     engine_busy_in
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] OWN_LAST = PW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [NUM_REQ-1:0]   rvalid_q, rvalid_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 err_q, err_d;
  logic                 to_q, to_d;
  logic                 busy_q, busy_d;
  logic [WIDTH-1:0]     ea_q, ea_d;
  logic [WIDTH-1:0]     eb_q, eb_d;
  logic                 ev_q, ev_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic [PW-1:0]        win;
  logic                 found;
  logic [NUM_REQ-1:0]   win_oh;
  logic [NUM_REQ-1:0]   own_oh;

  // Search starts at ptr and wraps; first requester found wins.
  always_comb begin
    int idx;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr_q) + i) % NUM_REQ;
      if (!found && req_in[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_comb begin
    win_oh = '0;
    own_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_oh[i] = (win == PW'(i));
      own_oh[i] = (owner_q == PW'(i));
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    ack_d    = '0;
    rvalid_d = '0;
    result_d = result_q;
    err_d    = err_q;
    to_d     = to_q;
    ea_d     = ea_q;
    eb_d     = eb_q;
    ev_d     = 1'b0;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          ea_d    = a_in[int'(win)*WIDTH +: WIDTH];
          eb_d    = base_in[int'(win)*WIDTH +: WIDTH];
          owner_d = win;
          ack_d   = win_oh;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!engine_busy_in) begin
          ev_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Engine result takes priority over a same-cycle timeout.
        if (engine_valid_in) begin
          result_d = engine_b_in;
          err_d    = engine_error_in;
          to_d     = 1'b0;
          rvalid_d = own_oh;
          state_d  = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          result_d = '0;
          err_d    = 1'b1;
          to_d     = 1'b1;
          rvalid_d = own_oh;
          state_d  = S_RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        ptr_d   = (owner_q == OWN_LAST) ? '0 : owner_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      ack_q    <= '0;
      rvalid_q <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
      busy_q   <= 1'b0;
      ea_q     <= '0;
      eb_q     <= '0;
      ev_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      ack_q    <= ack_d;
      rvalid_q <= rvalid_d;
      result_q <= result_d;
      err_q    <= err_d;
      to_q     <= to_d;
      busy_q   <= busy_d;
      ea_q     <= ea_d;
      eb_q     <= eb_d;
      ev_q     <= ev_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ack_out          = ack_q;
  assign result_out       = result_q;
  assign result_valid_out = rvalid_q;
  assign result_error_out = err_q;
  assign timeout_out      = to_q;
  assign busy_out         = busy_q;
  assign engine_a_out     = ea_q;
  assign engine_base_out  = eb_q;
  assign engine_valid_out = ev_q;

endmodule

// File: tb/tb_modinv_arbiter.sv
// Directed bench for modinv_arbiter with a behavioural
// modular-inverse engine stub.
module tb_modinv_arbiter;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_bus, m_bus;
  logic [N-1:0]   ack, rv;
  logic [W-1:0]   res;
  logic           err, tmo, busy;
  logic [W-1:0]   ea, eb;
  logic           ev;
  logic [W-1:0]   eng_b;
  logic           eng_valid, eng_err, eng_busy;

  modinv_arbiter #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk_in(clk), .rst_in(rst),
    .req_in(req), .a_in(a_bus), .base_in(m_bus),
    .ack_out(ack), .result_out(res),
    .result_valid_out(rv), .result_error_out(err),
    .timeout_out(tmo), .busy_out(busy),
    .engine_a_out(ea), .engine_base_out(eb),
    .engine_valid_out(ev), .engine_b_in(eng_b),
    .engine_valid_in(eng_valid), .engine_error_in(eng_err),
    .engine_busy_in(eng_busy)
  );

  always #5 clk = ~clk;

  // Engine stub: brute-force inverse after eng_lat cycles.
  logic         eng_hang = 1'b0;
  logic         eng_force_busy = 1'b0;
  int           eng_lat = 2;
  int           ecnt = 0;
  logic         ebusy = 1'b0;
  logic [W-1:0] e_a, e_m;

  function automatic logic [W:0] inv(input logic [W-1:0] a,
                                     input logic [W-1:0] m);
    for (int x = 1; x < int'(m); x++)
      if ((int'(a) * x) % int'(m) == 1) return {1'b0, W'(x)};
    return {1'b1, {W{1'b0}}};
  endfunction

  initial begin
    eng_valid = 1'b0;
    eng_err   = 1'b0;
    eng_b     = '0;
  end

  always @(negedge clk) begin
    eng_valid = 1'b0;
    if (rst) begin
      ebusy = 1'b0;
    end else if (ebusy) begin
      if (ecnt <= 1) begin
        ebusy = 1'b0;
        {eng_err, eng_b} = inv(e_a, e_m);
        eng_valid = 1'b1;
      end else begin
        ecnt--;
      end
    end else if (ev && !eng_hang) begin
      ebusy = 1'b1;
      ecnt  = eng_lat;
      e_a   = ea;
      e_m   = eb;
    end
  end

  assign eng_busy = ebusy | eng_force_busy;

  int           nvec = 0;
  int           nerr = 0;
  int           cyc  = 0;
  int           acks[$];
  logic [N-1:0] auto_drop = '1;
  logic [N-1:0] rearm = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (ack[i]) begin
        acks.push_back(i);
        if (auto_drop[i]) req[i] = 1'b0;
      end
      if (rv[i] && rearm[i]) req[i] = 1'b1;
    end
  endtask

  task automatic wait_ack(output int who);
    int k = 0;
    who = -1;
    while (who < 0 && k < 60) begin
      step();
      k++;
      for (int i = 0; i < N; i++) if (ack[i]) who = i;
    end
    chk("ack_seen", 64'(who >= 0), 64'd1);
  endtask

  task automatic wait_res(output int who);
    int k = 0;
    who = -1;
    while (who < 0 && k < 100) begin
      step();
      k++;
      for (int i = 0; i < N; i++) if (rv[i]) who = i;
    end
    chk("result_seen", 64'(who >= 0), 64'd1);
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a,
                        input logic [W-1:0] m);
    a_bus[i*W +: W] = a;
    m_bus[i*W +: W] = m;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    int           idx;
    logic [W-1:0] a;
    logic [W-1:0] m;
    logic [W-1:0] r;
    logic         e;
  } vec_t;

  vec_t tbl[4];
  int   who, c0, k;
  logic [N-1:0] oh;
  int   exp_r[4];
  logic stall_ok;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 16'd3,  16'd11, 16'd4,  1'b0};
    tbl[1] = '{1, 16'd6,  16'd9,  16'd0,  1'b1};
    tbl[2] = '{3, 16'd7,  16'd26, 16'd15, 1'b0};
    tbl[3] = '{2, 16'd10, 16'd17, 16'd12, 1'b0};
    req   = '0;
    a_bus = '0;
    m_bus = '0;
    rst   = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_ev", 64'(ev), 64'd0);
    chk("rst_rv", 64'(rv), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[v]) begin
      set_op(tbl[v].idx, tbl[v].a, tbl[v].m);
      req[tbl[v].idx] = 1'b1;
      oh = '0;
      oh[tbl[v].idx] = 1'b1;
      wait_ack(who);
      chk($sformatf("v%0d_ack", v), 64'(ack), 64'(oh));
      chk($sformatf("v%0d_ev_early", v), 64'(ev), 64'd0);
      step();
      chk($sformatf("v%0d_ack_pulse", v), 64'(ack), 64'd0);
      chk($sformatf("v%0d_ev", v), 64'(ev), 64'd1);
      chk($sformatf("v%0d_ea", v), 64'(ea), 64'(tbl[v].a));
      chk($sformatf("v%0d_eb", v), 64'(eb), 64'(tbl[v].m));
      wait_res(who);
      chk($sformatf("v%0d_rv", v), 64'(rv), 64'(oh));
      if (!tbl[v].e)
        chk($sformatf("v%0d_res", v), 64'(res), 64'(tbl[v].r));
      chk($sformatf("v%0d_err", v), 64'(err), 64'(tbl[v].e));
      chk($sformatf("v%0d_tmo", v), 64'(tmo), 64'd0);
      step();
      chk($sformatf("v%0d_rv_pulse", v), 64'(rv), 64'd0);
    end

    // Engine busy holds the block in ISSUE.
    step();
    eng_force_busy = 1'b1;
    set_op(0, 16'd3, 16'd11);
    req[0] = 1'b1;
    wait_ack(who);
    stall_ok = 1'b1;
    repeat (3) begin
      step();
      if (ev || !busy) stall_ok = 1'b0;
    end
    chk("stall_hold", 64'(stall_ok), 64'd1);
    eng_force_busy = 1'b0;
    step();
    chk("stall_release_ev", 64'(ev), 64'd1);
    wait_res(who);
    chk("stall_res", 64'(res), 64'd4);
    step();

    // All four request together from ptr=0.
    do_reset();
    set_op(0, 16'd5, 16'd7);   exp_r[0] = 3;
    set_op(1, 16'd2, 16'd9);   exp_r[1] = 5;
    set_op(2, 16'd7, 16'd26);  exp_r[2] = 15;
    set_op(3, 16'd10, 16'd17); exp_r[3] = 12;
    acks.delete();
    auto_drop = '1;
    req = 4'b1111;
    for (int i = 0; i < N; i++) begin
      wait_res(who);
      chk($sformatf("sim%0d_owner", i), 64'(who), 64'(i));
      chk($sformatf("sim%0d_res", i), 64'(res), 64'(exp_r[i]));
      chk($sformatf("sim%0d_err", i), 64'(err), 64'd0);
    end
    chk("sim_ack_count", 64'(acks.size()), 64'd4);
    for (int i = 0; i < acks.size() && i < N; i++)
      chk($sformatf("sim_ack_order%0d", i), 64'(acks[i]), 64'(i));
    step();

    // Requester 0 re-requests at once while requester 2 is held.
    acks.delete();
    set_op(0, 16'd3, 16'd11);
    set_op(2, 16'd10, 16'd17);
    auto_drop = 4'b1011;
    rearm     = 4'b0001;
    req       = 4'b0101;
    k = 0;
    while (acks.size() < 6 && k < 400) begin
      step();
      k++;
    end
    req   = '0;
    rearm = '0;
    auto_drop = '1;
    chk("hog_grants", 64'(acks.size() >= 6), 64'd1);
    for (int i = 1; i < acks.size() && i < 6; i++)
      chk($sformatf("hog_alt%0d", i),
          64'(acks[i] != acks[i-1] &&
              (acks[i] == 0 || acks[i] == 2)), 64'd1);
    wait_res(who);
    repeat (2) step();

    // Timeout with an engine that never answers.
    eng_hang = 1'b1;
    set_op(2, 16'd5, 16'd7);
    req[2] = 1'b1;
    wait_ack(who);
    k = 0;
    while (!ev && k < 20) begin
      step();
      k++;
    end
    c0 = cyc;
    wait_res(who);
    chk("to_latency", 64'(cyc - c0), 64'(TO));
    chk("to_rv", 64'(rv), 64'b0100);
    chk("to_err", 64'(err), 64'd1);
    chk("to_flag", 64'(tmo), 64'd1);
    chk("to_res", 64'(res), 64'd0);
    step();

    // Reset while requester 1 waits on the engine.
    set_op(1, 16'd2, 16'd9);
    req[1] = 1'b1;
    wait_ack(who);
    chk("mr_owner", 64'(who), 64'd1);
    repeat (3) step();
    #2;
    rst = 1'b1;
    #1;
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_err", 64'(err), 64'd0);
    chk("mr_tmo", 64'(tmo), 64'd0);
    chk("mr_ea", 64'(ea), 64'd0);
    chk("mr_eb", 64'(eb), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    eng_hang = 1'b0;
    acks.delete();
    set_op(2, 16'd7, 16'd26);
    set_op(3, 16'd10, 16'd17);
    req = 4'b1100;
    wait_ack(who);
    chk("mr_ack_ptr0", 64'(ack), 64'b0100);
    wait_res(who);
    chk("mr_rv", 64'(rv), 64'b0100);
    chk("mr_res", 64'(res), 64'd15);
    wait_res(who);
    chk("mr_rv2", 64'(rv), 64'b1000);
    chk("mr_res2", 64'(res), 64'd12);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
